// File: rtl/aes_pkg.sv
// Shared AES primitives: round-count constants, forward S-box and GF(2^8) doubling.
// Imported by both the key-expansion stage and the encryption datapath.
package aes_pkg;

  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Blocks use bit 0 as MSB; byte n sits at row n%4, column n/4.
module aes_round
  import aes_pkg::*;
(
  input  logic [0:127] state_in,
  input  logic [0:127] round_key,
  input  logic         final_round,
  output logic [0:127] state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int n = 0; n < 16; n++) begin
      sb[n] = sbox(state_in[8*n +: 8]);
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c + r] = sb[4*((c + r) % 4) + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]     = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    state_out = '0;
    for (int n = 0; n < 16; n++) begin
      state_out[8*n +: 8] = (final_round ? sr[n] : mc[n]) ^ round_key[8*n +: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES encryptor: one round per clock from an externally held key schedule.
// Start is accepted only when idle with a valid schedule; done pulses with the ciphertext.
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int Nk = AES128_NK,
  parameter int Nr = AES128_NR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_valid,
  input  logic [0:128*(Nr+1)-1]  w,
  input  logic                   start,
  input  logic [0:127]           plaintext,
  output logic                   busy,
  output logic                   done,
  output logic [0:127]           ciphertext
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUND = 1'b1;
  localparam logic [3:0] NR_L  = 4'(Nr);

  logic [0:0]   fsm;
  logic [3:0]   rnd;
  logic [0:127] s;
  logic [0:127] round_key;
  logic [0:127] next_s;
  logic         final_round;

  // Nk only documents the pairing with key expansion; the datapath depends on Nr.
  logic unused_nk;
  assign unused_nk = ^32'(Nk);

  always_comb begin
    round_key = '0;
    for (int i = 0; i <= Nr; i++) begin
      if (rnd == 4'(i)) round_key = w[128*i +: 128];
    end
  end

  assign final_round = (rnd == NR_L);

  aes_round u_round (
    .state_in    (s),
    .round_key   (round_key),
    .final_round (final_round),
    .state_out   (next_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      rnd        <= '0;
      s          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start && key_valid) begin
            s    <= plaintext ^ w[0 +: 128];
            rnd  <= 4'd1;
            busy <= 1'b1;
            fsm  <= ROUND;
          end
        end
        ROUND: begin
          s <= next_s;
          if (final_round) begin
            ciphertext <= next_s;
            done       <= 1'b1;
            busy       <= 1'b0;
            fsm        <= IDLE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core: reference AES model built from GF(2^8) arithmetic,
// key schedule expanded in the bench, monitor checks done/ciphertext/latency/busy each cycle.
module tb_aes_encrypt_core;

  localparam int NR = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  key_valid;
  logic [0:128*(NR+1)-1] w;
  logic                  start;
  logic [0:127]          plaintext;
  logic                  busy;
  logic                  done;
  logic [0:127]          ciphertext;

  aes_encrypt_core #(.Nk(4), .Nr(NR)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .w          (w),
    .start      (start),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] tb_sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [1407:0] key_expand(input logic [127:0] key);
    logic [31:0]   wd [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] res;
    for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = wd[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      wd[i] = wd[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = wd[i];
    return res;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1407:0] ks);
    logic [7:0]   st [4][4];
    logic [7:0]   tmp [4][4];
    logic [127:0] res;
    for (int n = 0; n < 16; n++) st[n%4][n/4] = pt[127-8*n -: 8] ^ ks[1407-8*n -: 8];
    for (int round = 1; round <= NR; round++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = tb_sbox[st[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (round < NR) begin
          st[0][c] = gmul(8'h02, tmp[0][c]) ^ gmul(8'h03, tmp[1][c]) ^ tmp[2][c] ^ tmp[3][c];
          st[1][c] = tmp[0][c] ^ gmul(8'h02, tmp[1][c]) ^ gmul(8'h03, tmp[2][c]) ^ tmp[3][c];
          st[2][c] = tmp[0][c] ^ tmp[1][c] ^ gmul(8'h02, tmp[2][c]) ^ gmul(8'h03, tmp[3][c]);
          st[3][c] = gmul(8'h03, tmp[0][c]) ^ tmp[1][c] ^ tmp[2][c] ^ gmul(8'h02, tmp[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
        end
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ ks[1407 - 128*round - 8*(4*c+r) -: 8];
      end
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = st[n%4][n/4];
    return res;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      logic busy_exp;
      if (done) begin
        if (exp_q.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          chk("ciphertext", ciphertext, e.ct);
          chk("latency", 128'(cyc - e.acc), 128'(NR));
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].acc + NR) begin
        fail_event("missing_done");
        void'(exp_q.pop_front());
      end
      busy_exp = (exp_q.size() > 0) && (cyc >= exp_q[0].acc) && (cyc < exp_q[0].acc + NR);
      chk("busy", 128'(busy), 128'(busy_exp));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] ct);
    exp_t e;
    e.ct  = ct;
    e.acc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [127:0] pt, input logic [127:0] ct, output int acc);
    plaintext = pt;
    start     = 1'b1;
    push(ct);
    acc = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      fail_event("idle_timeout");
      exp_q.delete();
    end
    step();
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1407:0] ks_b, ks_c, ks;
    logic [127:0]  pt, key, ct_hold;
    int            acc;

    rst = 1'b1; start = 1'b0; key_valid = 1'b0; w = '0; plaintext = '0;
    build_sbox();
    ks_b = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    ks_c = key_expand(128'h000102030405060708090a0b0c0d0e0f);

    repeat (3) step();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_ct", ciphertext, 128'd0);
    rst = 1'b0;
    step();

    // App. C.1
    w = ks_c; key_valid = 1'b1;
    issue(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, acc);
    wait_idle();

    // App. B with round-1 intermediate state
    w = ks_b;
    issue(128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, acc);
    step();
    chk("round1_state", u_dut.s, 128'ha49c7ff2689f352b6b5bea43026a5049);
    wait_idle();

    // Back-to-back, start held across the done cycle, schedule swapped in the done cycle
    w = ks_b;
    plaintext = 128'h3243f6a8885a308d313198a2e0370734;
    start = 1'b1;
    push(128'h3925841d02dc09fbdc118597196a0b32);
    acc = cyc + 1;
    wait_until(acc + NR);
    w = ks_c;
    plaintext = 128'h00112233445566778899aabbccddeeff;
    push(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    step();
    start = 1'b0;
    wait_idle();

    // Gating: no schedule -> nothing happens
    key_valid = 1'b0;
    start = 1'b1;
    repeat (6) step();
    start = 1'b0;
    key_valid = 1'b1;
    step();

    // Start pulses during rounds 3 and 7 are ignored
    w = ks_b;
    ct_hold = 128'h3925841d02dc09fbdc118597196a0b32;
    issue(128'h3243f6a8885a308d313198a2e0370734, ct_hold, acc);
    wait_until(acc + 2);
    start = 1'b1; step(); start = 1'b0;
    wait_until(acc + 6);
    start = 1'b1; step(); start = 1'b0;
    wait_idle();
    repeat (3) step();
    chk("ct_held", ciphertext, ct_hold);

    // Reset in the middle of round 5
    w = ks_c;
    issue(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, acc);
    wait_until(acc + 4);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_done", 128'(done), 128'd0);
    chk("midrst_ct", ciphertext, 128'd0);
    step();
    rst = 1'b0;
    step();
    issue(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, acc);
    wait_idle();

    // Randomized keys and plaintexts against the reference model
    for (int k = 0; k < 10; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      ks  = key_expand(key);
      w   = ks;
      repeat ($urandom_range(0, 3)) step();
      issue(pt, ref_encrypt(pt, ks), acc);
      if ($urandom_range(0, 1) == 1) begin
        wait_until(acc + 1 + int'($urandom_range(0, 7)));
        start = 1'b1; step(); start = 1'b0;
      end
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
